ysyx_23060072_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between NREQ writeback sources
//  (ALU, LSU, CSR, mult/div) using round-robin arbitration.

---
 rtl/ysyx_23060072_wb_arbiter.sv | 92 +++++++++
 tb/tb_ysyx_23060072_wb_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060072_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NREQ writeback
// sources; the winner is registered onto the wb_* outputs with one cycle of latency.
module ysyx_23060072_wb_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32,
  localparam int SW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ*AW-1:0] req_addr_i,
  input  logic [NREQ*DW-1:0] req_data_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic              wb_flag_o,
  output logic [AW-1:0]     wb_addr_o,
  output logic [DW-1:0]     wb_data_o,
  output logic [SW-1:0]     wb_src_o
);

  logic [SW-1:0] last_q;
  logic          wb_flag_q;
  logic [AW-1:0] wb_addr_q;
  logic [DW-1:0] wb_data_q;
  logic [SW-1:0] wb_src_q;

  logic          grant_found_d;
  logic [SW-1:0] grant_idx_d;
  logic [SW-1:0] probe_idx;
  logic [AW-1:0] win_addr_d;
  logic [DW-1:0] win_data_d;

  function automatic logic [SW-1:0] rr_index(input logic [SW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NREQ;
    return SW'(s);
  endfunction

  // Search starts one past the last winner, so the most recently served requester
  // has the lowest priority in the next cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    grant_found_d = 1'b0;
    grant_idx_d   = '0;
    probe_idx     = '0;
    if (!stall_i && !rst) begin
      for (int k = 1; k <= NREQ; k++) begin
        probe_idx = rr_index(last_q, k);
        if (!grant_found_d && req_valid_i[probe_idx]) begin
          grant_found_d = 1'b1;
          grant_idx_d   = probe_idx;
        end
      end
    end
  end

  always_comb begin
    req_ready_o              = '0;
    req_ready_o[grant_idx_d] = grant_found_d;
    win_addr_d               = req_addr_i[grant_idx_d*AW +: AW];
    win_data_d               = req_data_i[grant_idx_d*DW +: DW];
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from the values seen before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q    <= SW'(NREQ - 1);
      wb_flag_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_src_q  <= '0;
    end else begin
      wb_flag_q <= 1'b0;
      if (grant_found_d) begin
        // x0 requests are consumed and advance the pointer but never write.
        last_q    <= grant_idx_d;
        wb_flag_q <= (win_addr_d != '0);
        wb_addr_q <= win_addr_d;
        wb_data_q <= win_data_d;
        wb_src_q  <= grant_idx_d;
      end
    end
  end

  assign wb_flag_o = wb_flag_q;
  assign wb_addr_o = wb_addr_q;
  assign wb_data_o = wb_data_q;
  assign wb_src_o  = wb_src_q;

endmodule

// File: tb/tb_ysyx_23060072_wb_arbiter.sv
// Directed, table-driven bench for the round-robin writeback arbiter, plus
// hand-written sequences for reset behaviour.
module tb_ysyx_23060072_wb_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int SW   = 2;

  localparam logic [DW-1:0] D0 = 32'h0000_00D0;
  localparam logic [DW-1:0] D1 = 32'h0000_00D1;
  localparam logic [DW-1:0] D2 = 32'h0000_00D2;
  localparam logic [DW-1:0] D3 = 32'h0000_00D3;
  localparam logic [DW-1:0] DB = 32'hDEAD_BEEF;

  localparam logic [NREQ*AW-1:0] A_STD = {5'd4, 5'd3, 5'd2, 5'd1};
  localparam logic [NREQ*AW-1:0] A_T2  = {5'd4, 5'd5, 5'd2, 5'd1};
  localparam logic [NREQ*AW-1:0] A_X0  = {5'd4, 5'd3, 5'd0, 5'd1};
  localparam logic [NREQ*DW-1:0] D_STD = {D3, D2, D1, D0};
  localparam logic [NREQ*DW-1:0] D_T2  = {D3, DB, D1, D0};

  logic               clk;
  logic               rst;
  logic               stall_i;
  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ*AW-1:0] req_addr_i;
  logic [NREQ*DW-1:0] req_data_i;
  logic [NREQ-1:0]    req_ready_o;
  logic               wb_flag_o;
  logic [AW-1:0]      wb_addr_o;
  logic [DW-1:0]      wb_data_o;
  logic [SW-1:0]      wb_src_o;

  typedef struct packed {
    logic               stall;
    logic [NREQ-1:0]    valid;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] data;
    logic [NREQ-1:0]    exp_ready;
    logic               exp_flag;
    logic [AW-1:0]      exp_addr;
    logic [DW-1:0]      exp_data;
    logic [SW-1:0]      exp_src;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  ysyx_23060072_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .req_valid_i (req_valid_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .wb_flag_o   (wb_flag_o),
    .wb_addr_o   (wb_addr_o),
    .wb_data_o   (wb_data_o),
    .wb_src_o    (wb_src_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic stall, input logic [NREQ-1:0] valid,
                     input logic [NREQ*AW-1:0] addr, input logic [NREQ*DW-1:0] data,
                     input logic [NREQ-1:0] exp_ready, input logic exp_flag,
                     input logic [AW-1:0] exp_addr, input logic [DW-1:0] exp_data,
                     input logic [SW-1:0] exp_src);
    vec_t v;
    v.stall = stall; v.valid = valid; v.addr = addr; v.data = data;
    v.exp_ready = exp_ready; v.exp_flag = exp_flag; v.exp_addr = exp_addr;
    v.exp_data = exp_data; v.exp_src = exp_src;
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic flag, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic [SW-1:0] src);
    check({tag, ".flag"}, 64'(wb_flag_o), 64'(flag));
    check({tag, ".addr"}, 64'(wb_addr_o), 64'(addr));
    check({tag, ".data"}, 64'(wb_data_o), 64'(data));
    check({tag, ".src"},  64'(wb_src_o),  64'(src));
  endtask

  initial begin
    // T3: pointer starts at NREQ-1, so the first grant is requester 0.
    for (int r = 0; r < 2; r++) begin
      add(0, 4'b1111, A_STD, D_STD, 4'b0001, 1, 5'd1, D0, 2'd0);
      add(0, 4'b1111, A_STD, D_STD, 4'b0010, 1, 5'd2, D1, 2'd1);
      add(0, 4'b1111, A_STD, D_STD, 4'b0100, 1, 5'd3, D2, 2'd2);
      add(0, 4'b1111, A_STD, D_STD, 4'b1000, 1, 5'd4, D3, 2'd3);
    end
    // T4: after a grant to 3, only 0 and 2 alternate.
    for (int r = 0; r < 2; r++) begin
      add(0, 4'b0101, A_STD, D_STD, 4'b0001, 1, 5'd1, D0, 2'd0);
      add(0, 4'b0101, A_STD, D_STD, 4'b0100, 1, 5'd3, D2, 2'd2);
    end
    // T2: lone requester 2, then an idle cycle holding addr/data/src.
    add(0, 4'b0100, A_T2, D_T2, 4'b0100, 1, 5'd5, DB, 2'd2);
    add(0, 4'b0000, A_T2, D_T2, 4'b0000, 0, 5'd5, DB, 2'd2);
    // T5: x0 write is consumed without a write; next grant moves on to 2.
    add(0, 4'b0010, A_X0, D_STD, 4'b0010, 0, 5'd0, D1, 2'd1);
    add(0, 4'b1111, A_STD, D_STD, 4'b0100, 1, 5'd3, D2, 2'd2);
    // T6: stall blocks grants and freezes the pointer (last stays 2).
    for (int r = 0; r < 3; r++)
      add(1, 4'b0011, A_STD, D_STD, 4'b0000, 0, 5'd3, D2, 2'd2);
    add(0, 4'b0011, A_STD, D_STD, 4'b0001, 1, 5'd1, D0, 2'd0);
    add(0, 4'b0011, A_STD, D_STD, 4'b0010, 1, 5'd2, D1, 2'd1);

    rst = 1'b1; stall_i = 1'b0; req_valid_i = 4'b1111;
    req_addr_i = A_STD; req_data_i = D_STD;
    #12;
    check("reset.ready", 64'(req_ready_o), 64'h0);
    check_outputs("reset", 0, 5'd0, 32'd0, 2'd0);
    @(negedge clk);
    rst = 1'b0; req_valid_i = '0;

    foreach (vecs[i]) begin
      @(negedge clk);
      stall_i = vecs[i].stall; req_valid_i = vecs[i].valid;
      req_addr_i = vecs[i].addr; req_data_i = vecs[i].data;
      #1;
      check($sformatf("v%0d.ready", i), 64'(req_ready_o), 64'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      check_outputs($sformatf("v%0d", i), vecs[i].exp_flag, vecs[i].exp_addr,
                    vecs[i].exp_data, vecs[i].exp_src);
    end

    // T1: with last=1 and all valid, req 2 wins; then reset mid-cycle clears at once.
    @(negedge clk);
    stall_i = 1'b0; req_valid_i = 4'b1111; req_addr_i = A_STD; req_data_i = D_STD;
    @(posedge clk);
    #1;
    check("t1.pre_flag", 64'(wb_flag_o), 64'h1);
    check("t1.pre_src",  64'(wb_src_o),  64'h2);
    #2;
    rst = 1'b1;
    #1;
    check("t1.rst_ready", 64'(req_ready_o), 64'h0);
    check_outputs("t1.rst", 0, 5'd0, 32'd0, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t1.post_ready", 64'(req_ready_o), 64'h1);
    @(posedge clk);
    #1;
    check_outputs("t1.post", 1, 5'd1, D0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
